// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : conv_pkg
// Brief   : Shared constants, result-width derivation and Sobel presets for
//           the streaming 3x3 convolution path.
// Revision: 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int c_ksize = 3;
  localparam int c_ntaps = c_ksize * c_ksize;

  // Kernel indices, row-major, 0 = top-left
  localparam int c_idx_tl = 0;
  localparam int c_idx_tm = 1;
  localparam int c_idx_tr = 2;
  localparam int c_idx_ml = 3;
  localparam int c_idx_mm = 4;
  localparam int c_idx_mr = 5;
  localparam int c_idx_bl = 6;
  localparam int c_idx_bm = 7;
  localparam int c_idx_br = 8;

  typedef logic signed [7:0] coef8_t;

  localparam coef8_t c_sobel_x [c_ntaps] = '{
    -8'sd1,  8'sd0,  8'sd1,
    -8'sd2,  8'sd0,  8'sd2,
    -8'sd1,  8'sd0,  8'sd1
  };

  localparam coef8_t c_sobel_y [c_ntaps] = '{
    -8'sd1, -8'sd2, -8'sd1,
     8'sd0,  8'sd0,  8'sd0,
     8'sd1,  8'sd2,  8'sd1
  };

  // Product is DATA+COEF+1 bits; nine terms need four more guard bits.
  function automatic int out_width(input int data_width, input int coef_width);
    return data_width + coef_width + 5;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module  : line_buffer
// Brief   : Circular delay line of IMG_WIDTH entries; dout is the sample
//           written IMG_WIDTH enabled cycles ago.
// Revision: 1.0 - initial release
// ============================================================================
module line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int c_ptr_w = $clog2(IMG_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [IMG_WIDTH];
  logic [c_ptr_w-1:0]    r_ptr;

  assign dout = r_mem[r_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IMG_WIDTH; i++) r_mem[i] <= '0;
      r_ptr <= '0;
    end else if (en) begin
      r_mem[r_ptr] <= din;
      r_ptr        <= (r_ptr == c_ptr_w'(IMG_WIDTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv2d_stream.sv
`default_nettype none
// ============================================================================
// Module  : conv2d_stream
// Brief   : Streaming 3x3 signed convolution over a raster frame with line
//           buffering, loadable kernel, optional ReLU and valid/ready flow.
// Revision: 1.0 - initial release
// ============================================================================
module conv2d_stream
  import conv_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int COEF_WIDTH = 8,
  parameter  int IMG_WIDTH  = 28,
  parameter  int IMG_HEIGHT = 28,
  localparam int OUT_WIDTH  = out_width(DATA_WIDTH, COEF_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_last,
  input  logic                        coef_we,
  input  logic [3:0]                  coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  input  logic                        relu_en,
  output logic                        busy
);

  localparam int c_prod_w = DATA_WIDTH + COEF_WIDTH + 1;
  localparam int c_col_w  = $clog2(IMG_WIDTH);
  localparam int c_row_w  = $clog2(IMG_HEIGHT);

  logic                         r_ready_en;
  logic                         w_adv;
  logic                         w_accept;
  logic [c_col_w-1:0]           r_col;
  logic [c_row_w-1:0]           r_row;
  logic                         w_win_ok;
  logic                         w_frame_end;
  logic [DATA_WIDTH-1:0]        w_lb0_out;
  logic [DATA_WIDTH-1:0]        w_lb1_out;
  logic [DATA_WIDTH-1:0]        r_win [c_ntaps];
  logic                         r_win_valid;
  logic                         r_win_last;
  logic                         r_win_relu;
  logic signed [COEF_WIDTH-1:0] r_coef [c_ntaps];
  logic signed [c_prod_w-1:0]   w_prod [c_ntaps];
  logic signed [c_prod_w-1:0]   r_prod [c_ntaps];
  logic                         r_s1_valid;
  logic                         r_s1_last;
  logic                         r_s1_relu;
  logic signed [OUT_WIDTH-1:0]  w_sum;
  logic signed [OUT_WIDTH-1:0]  w_result;

  // Whole datapath stalls together so a held result never gets overwritten.
  assign w_adv       = !out_valid || out_ready;
  assign in_ready    = w_adv && r_ready_en;
  assign w_accept    = in_valid && in_ready;
  assign w_win_ok    = (r_row >= c_row_w'(2)) && (r_col >= c_col_w'(2));
  assign w_frame_end = (r_row == c_row_w'(IMG_HEIGHT - 1)) &&
                       (r_col == c_col_w'(IMG_WIDTH - 1));

  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .IMG_WIDTH(IMG_WIDTH)) u_lb0 (
    .clk (clk),
    .rst (rst),
    .en  (w_accept),
    .din (in_data),
    .dout(w_lb0_out)
  );

  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .IMG_WIDTH(IMG_WIDTH)) u_lb1 (
    .clk (clk),
    .rst (rst),
    .en  (w_accept),
    .din (w_lb0_out),
    .dout(w_lb1_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready_en <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      busy       <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        if (r_col == c_col_w'(IMG_WIDTH - 1)) begin
          r_col <= '0;
          r_row <= (r_row == c_row_w'(IMG_HEIGHT - 1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      // A pixel accepted alongside the final handshake already belongs to the next frame.
      if (w_accept)
        busy <= 1'b1;
      else if (out_valid && out_ready && out_last)
        busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < c_ntaps; k++) r_coef[k] <= '0;
    end else if (coef_we && !busy) begin
      for (int k = 0; k < c_ntaps; k++)
        if (coef_addr == 4'(k)) r_coef[k] <= coef_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < c_ntaps; k++) r_win[k] <= '0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_win_relu  <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int r = 0; r < c_ksize; r++) begin
          r_win[r*c_ksize + 0] <= r_win[r*c_ksize + 1];
          r_win[r*c_ksize + 1] <= r_win[r*c_ksize + 2];
        end
        r_win[c_idx_tr] <= w_lb1_out;
        r_win[c_idx_mr] <= w_lb0_out;
        r_win[c_idx_br] <= in_data;
        r_win_relu      <= relu_en;
      end
      if (w_adv) begin
        r_win_valid <= w_accept && w_win_ok;
        r_win_last  <= w_accept && w_frame_end;
      end
    end
  end

  genvar gk;
  generate
    for (gk = 0; gk < c_ntaps; gk++) begin : g_tap
      assign w_prod[gk] = $signed({1'b0, r_win[gk]}) * r_coef[gk];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < c_ntaps; k++) r_prod[k] <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_relu  <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < c_ntaps; k++) r_prod[k] <= w_prod[k];
      r_s1_valid <= r_win_valid;
      r_s1_last  <= r_win_last;
      r_s1_relu  <= r_win_relu;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < c_ntaps; k++) w_sum = w_sum + OUT_WIDTH'(r_prod[k]);
  end

  assign w_result = (r_s1_relu && w_sum[OUT_WIDTH-1]) ? '0 : w_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_s1_valid;
      out_last  <= r_s1_valid && r_s1_last;
      if (r_s1_valid) out_data <= w_result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv2d_stream
// Brief   : Directed self-checking bench for conv2d_stream on a 4x4 frame.
// Revision: 1.0 - initial release
// ============================================================================
module tb_conv2d_stream;
  import conv_pkg::*;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int OW = DW + CW + 5;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic                 out_last;
  logic                 coef_we;
  logic [3:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 relu_en;
  logic                 busy;

  conv2d_stream #(
    .DATA_WIDTH(DW), .COEF_WIDTH(CW), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .relu_en  (relu_en),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint got_data [$];
  bit     got_last [$];
  bit     acc;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Handshakes complete on the next posedge; record them at the negedge before.
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      got_data.push_back(longint'(out_data));
      got_last.push_back(out_last);
    end

  always @(posedge clk) acc = in_valid && in_ready;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_kernel(input coef8_t k [c_ntaps]);
    for (int i = 0; i < c_ntaps; i++) begin
      coef_we   = 1'b1;
      coef_addr = 4'(i);
      coef_data = k[i];
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic send_pixels(input int n, input bit all_max);
    for (int i = 0; i < n; i++) begin
      int b;
      in_valid = 1'b1;
      in_data  = all_max ? 8'd255 : 8'(i);
      b = 0;
      do begin
        tick();
        b++;
      end while (!acc && b < 200);
      if (!acc) check("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic stall_proc();
    int b;
    logic signed [OW-1:0] hold;
    b = 0;
    while (!out_valid && b < 200) begin
      tick();
      b++;
    end
    check("stall_wait_valid", longint'(out_valid), 1);
    out_ready = 1'b0;
    hold      = out_data;
    coef_we   = 1'b1;
    coef_addr = 4'd4;
    coef_data = 8'sd100;
    for (int i = 0; i < 5; i++) begin
      tick();
      coef_we = 1'b0;
      check("stall_in_ready", longint'(in_ready), 0);
      check("stall_hold", longint'(out_data), longint'(hold));
    end
    out_ready = 1'b1;
  endtask

  task automatic run_frame(input string tag, input bit all_max, input longint exp, input bit stall);
    int b;
    got_data.delete();
    got_last.delete();
    if (stall)
      fork
        send_pixels(W*H, all_max);
        stall_proc();
      join
    else
      send_pixels(W*H, all_max);
    check({tag, "_busy_mid"}, longint'(busy), 1);
    b = 0;
    while (got_data.size() < 4 && b < 100) begin
      tick();
      b++;
    end
    repeat (6) tick();
    check({tag, "_count"}, got_data.size(), 4);
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      check({tag, "_data"}, got_data[i], exp);
      check({tag, "_last"}, longint'(got_last[i]), (i == 3) ? 1 : 0);
    end
    check({tag, "_busy_end"}, longint'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    coef8_t k_neg [c_ntaps];
    coef8_t k_min [c_ntaps];
    for (int i = 0; i < c_ntaps; i++) begin
      k_neg[i] = -c_sobel_x[i];
      k_min[i] = -8'sd128;
    end

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    relu_en   = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_last", longint'(out_last), 0);
    check("rst_busy", longint'(busy), 0);
    rst = 1'b0;
    tick();
    check("in_ready_after_rst", longint'(in_ready), 1);

    load_kernel(c_sobel_x);
    run_frame("sobel_x", 1'b0, 8, 1'b0);
    load_kernel(c_sobel_y);
    run_frame("sobel_y", 1'b0, 32, 1'b0);

    load_kernel(k_neg);
    relu_en = 1'b1;
    run_frame("relu_on", 1'b0, 0, 1'b0);
    relu_en = 1'b0;
    run_frame("relu_off", 1'b0, -8, 1'b0);

    load_kernel(k_min);
    run_frame("extreme", 1'b1, -293760, 1'b0);

    load_kernel(c_sobel_y);
    run_frame("stall", 1'b0, 32, 1'b1);

    load_kernel(c_sobel_x);
    send_pixels(7, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_out_data", longint'(out_data), 0);
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_busy", longint'(busy), 0);
    tick();
    rst = 1'b0;
    tick();
    load_kernel(c_sobel_x);
    run_frame("after_rst", 1'b0, 8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv2d_stream.md
# conv2d_stream

Parametrised streaming 3x3 convolution engine for the CNN feature-extraction path. It replaces the fixed-kernel, window-only convolver with true 2D line buffering for an IMG_WIDTH x IMG_HEIGHT raster. It adds a runtime-loadable signed kernel, valid/ready backpressure on both sides, optional ReLU, and frame-boundary tagging. It sits between the pixel source (camera or QR binariser) and the pooling stage.

## Interface
- DATA_WIDTH, 8, unsigned pixel width
- COEF_WIDTH, 8, signed kernel coefficient width
- IMG_WIDTH, 28, pixels per row (>= 3)
- IMG_HEIGHT, 28, rows per frame (>= 3)
- OUT_WIDTH, DATA_WIDTH+COEF_WIDTH+5, signed result width, derived and not overridden
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  pixel present
- in_ready  out  1  pixel accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH  unsigned pixel, raster order
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  OUT_WIDTH  signed convolution result
- out_last  out  1  marks the final result of a frame
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  kernel index 0..8, row-major, 0 = top-left
- coef_data  in  COEF_WIDTH  signed coefficient
- relu_en  in  1  clamp negative results to 0
- busy  out  1  frame in progress

## Operation
- Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) advance on each accepted pixel. col wraps to 0 and increments row. Accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1) returns both counters to 0.
- Two line buffers of depth IMG_WIDTH hold the previous two rows. A 3x3 register window shifts by one column per accepted pixel.
- Window valid only when row >= 2 and col >= 2 for the pixel just accepted. Only valid-region outputs are produced: (IMG_WIDTH-2)*(IMG_HEIGHT-2) per frame, with no padding.
- Result = sum over k of {1'b0,pixel_k} * coef_k, computed signed at OUT_WIDTH. There is no overflow at any parameter setting.
- relu_en is sampled with the window. When set, a negative result is output as 0.
- out_last is asserted with the result whose window bottom-right is pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- busy rises on the first accepted pixel of a frame. It falls when the out_last result is consumed.
- coef_we is honoured only while busy=0. Writes while busy=1 are dropped, so the kernel is constant within a frame.
- Reset values: all coefficients 0, counters 0, window and line buffers 0, out_valid 0, out_data 0, out_last 0, busy 0. in_ready is 1 one cycle after reset deasserts.
- Reset mid-frame aborts the frame. Any partial output is discarded and the next accepted pixel is (0,0).

## Timing
- Pipeline has 2 register stages: stage 1 holds the 9 products, stage 2 holds the sum plus ReLU. out_data is registered.
- Latency: a pixel accepted at edge N that completes a valid window gives out_valid=1 after edge N+2, provided there are no stalls.
- Advance condition: adv = !out_valid || out_ready. in_ready = adv. All stages, the window, the line buffers and the counters move only on adv.
- While out_valid && !out_ready, out_data and out_last hold stable and no pixel is accepted.
- Full throughput is 1 pixel per cycle when out_ready stays high.
- in_valid may drop at any time. Bubbles propagate as out_valid=0 with no state corruption.

## Structure
- Shared package conv_pkg holds:
  - the OUT_WIDTH derivation;
  - KSIZE=3 and NTAPS=9 constants;
  - coefficient index constants;
  - the Sobel-X and Sobel-Y preset values used by benches.
- Sub-module line_buffer, parametrised by DATA_WIDTH and IMG_WIDTH. It is a single-port circular delay line of IMG_WIDTH entries with an enable input, instantiated twice.

## Test plan
- IMG 4x4 with pixels 0..15 in raster order, Sobel-X loaded (-1,0,1,-2,0,2,-1,0,1) -> exactly 4 outputs, each +8. out_last on the 4th. busy falls after it is consumed.
- Same frame with Sobel-Y (-1,-2,-1,0,0,0,1,2,1) -> 4 outputs, each +32.
- Negated Sobel-X with relu_en=1 -> 4 outputs of 0. With relu_en=0 -> 4 outputs of -8.
- All pixels 255, all coefs -128 -> each output -293760, with no wrap.
- Hold out_ready low for 5 cycles mid-frame -> in_ready low, out_data stable, no output lost or duplicated against the reference model. Also issue coef_we during the frame -> the results are unchanged.
- Assert rst after 7 pixels of a frame, then send a full 4x4 frame -> only the 4 correct outputs of the new frame appear. All outputs read 0 during reset.
